// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: boots by checking sysid ID/timestamp, then shares the slave with one host requester.
// Optional periodic re-check is enabled by defining SYSID_RECHECK_EN.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1508275814,
  parameter logic [31:0] RECHECK_CYCLES = 32'd50_000_000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  output logic        sid_address_o,
  input  logic [31:0] sid_readdata_i,
  input  logic        host_req_i,
  input  logic        host_addr_i,
  output logic        host_ack_o,
  output logic [31:0] host_rdata_o,
  output logic        check_done_o,
  output logic        id_ok_o,
  output logic [31:0] id_value_o,
  output logic [31:0] ts_value_o
);
  localparam logic [2:0] CHK_ID = 3'd0;
  localparam logic [2:0] CHK_TS = 3'd1;
  localparam logic [2:0] IDLE   = 3'd2;
  localparam logic [2:0] HOST   = 3'd3;
  localparam logic [2:0] ACK    = 3'd4;
  logic [2:0]  state_q, state_d;
  logic        addr_q, addr_d, ack_q, ack_d, done_q, done_d, ok_q, ok_d;
  logic [31:0] rdata_q, rdata_d, id_q, id_d, ts_q, ts_d;
  logic        recheck;
`ifdef SYSID_RECHECK_EN
  logic [31:0] cnt_q, cnt_d;
  logic        pend_q, pend_d, wrap;
  assign wrap    = done_q && (cnt_q == RECHECK_CYCLES - 32'd1);
  assign recheck = pend_q;
  always_comb begin
    cnt_d  = done_q ? (wrap ? 32'd0 : cnt_q + 32'd1) : cnt_q;
    // a wrap coinciding with service re-arms rather than being lost
    pend_d = wrap | (pend_q & (state_q != IDLE));
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end
`else
  logic unused_recheck;
  assign unused_recheck = ^RECHECK_CYCLES;
  assign recheck        = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    done_d  = done_q;
    ok_d    = ok_q;
    id_d    = id_q;
    ts_d    = ts_q;
    case (state_q)
      CHK_ID: begin
        id_d    = sid_readdata_i;
        addr_d  = 1'b1;
        state_d = CHK_TS;
      end
      CHK_TS: begin
        ts_d    = sid_readdata_i;
        done_d  = 1'b1;
        ok_d    = (id_q == EXPECTED_ID) && (sid_readdata_i == EXPECTED_TS);
        state_d = IDLE;
      end
      IDLE: begin
        addr_d  = recheck ? 1'b0 : (host_req_i ? host_addr_i : addr_q);
        state_d = recheck ? CHK_ID : (host_req_i ? HOST : IDLE);
      end
      HOST: begin
        rdata_d = sid_readdata_i;
        ack_d   = 1'b1;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = CHK_ID;
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= CHK_ID;
      addr_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end
  assign sid_address_o = addr_q;
  assign host_ack_o    = ack_q;
  assign host_rdata_o  = rdata_q;
  assign check_done_o  = done_q;
  assign id_ok_o       = ok_q;
  assign id_value_o    = id_q;
  assign ts_value_o    = ts_q;
endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl: randomized host traffic and boot-check scenarios against a transaction-level model.
module tb_sysid_check_ctrl;
  localparam logic [31:0] EXP_TS = 32'd1508275814;
`ifdef SYSID_RECHECK_EN
  localparam int SLACK = 2;
`else
  localparam int SLACK = 0;
`endif
  logic        clock_i = 1'b0, reset_i = 1'b1, host_req_i = 1'b0, host_addr_i = 1'b0;
  logic        sid_address_o, host_ack_o, check_done_o, id_ok_o;
  logic [31:0] sid_readdata_i, host_rdata_o, id_value_o, ts_value_o;
  logic [31:0] mem [2];
  int          n_run = 0, n_fail = 0;
  sysid_check_ctrl #(.RECHECK_CYCLES(32'd16)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .sid_address_o(sid_address_o),
    .sid_readdata_i(sid_readdata_i), .host_req_i(host_req_i), .host_addr_i(host_addr_i),
    .host_ack_o(host_ack_o), .host_rdata_o(host_rdata_o), .check_done_o(check_done_o),
    .id_ok_o(id_ok_o), .id_value_o(id_value_o), .ts_value_o(ts_value_o)
  );
  assign sid_readdata_i = mem[sid_address_o];
  always #5 clock_i = ~clock_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask
  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask
  task automatic wait_ack(output int lat);
    lat = 0;
    while (!host_ack_o && lat < 12) begin
      tick();
      lat++;
    end
  endtask
  task automatic host_read(input logic a);
    int lat;
    logic [31:0] exp;
    exp = mem[a];
    host_req_i  = 1'b1;
    host_addr_i = a;
    wait_ack(lat);
    check("rd_lat", 32'(lat >= 2 && lat <= 2 + SLACK), 32'd1);
    check("rd_data", host_rdata_o, exp);
    check("rd_sid_addr", 32'(sid_address_o), 32'(a));
    host_req_i = 1'b0;
    tick();
    check("rd_ack_pulse", 32'(host_ack_o), 32'd0);
  endtask
  initial begin
    int lat;
    mem[0] = 32'd0;
    mem[1] = EXP_TS;
    // boot with a matching slave
    tick();
    check("rst_ack", 32'(host_ack_o), 32'd0);
    check("rst_done", 32'(check_done_o), 32'd0);
    check("rst_ok", 32'(id_ok_o), 32'd0);
    check("rst_id", id_value_o, 32'd0);
    check("rst_ts", ts_value_o, 32'd0);
    check("rst_rdata", host_rdata_o, 32'd0);
    check("rst_sid", 32'(sid_address_o), 32'd0);
    do_reset();
    repeat (3) tick();
    check("boot_done", 32'(check_done_o), 32'd1);
    check("boot_ok", 32'(id_ok_o), 32'd1);
    check("boot_id", id_value_o, 32'd0);
    check("boot_ts", ts_value_o, EXP_TS);
    // wrong ID
    mem[0] = 32'h1;
    do_reset();
    tick();
    check("bad_mid_ok", 32'(id_ok_o), 32'd0);
    check("bad_mid_done", 32'(check_done_o), 32'd0);
    tick();
    tick();
    check("bad_ok", 32'(id_ok_o), 32'd0);
    check("bad_done", 32'(check_done_o), 32'd1);
    check("bad_id", id_value_o, 32'h1);
    // request held through reset and the boot check
    mem[0] = 32'd0;
    reset_i     = 1'b1;
    host_req_i  = 1'b1;
    host_addr_i = 1'b1;
    tick();
    tick();
    check("held_rst_ack", 32'(host_ack_o), 32'd0);
    reset_i = 1'b0;
    wait_ack(lat);
    check("held_lat", 32'(lat == 4), 32'd1);
    check("held_data", host_rdata_o, EXP_TS);
    host_req_i = 1'b0;
    tick();
    check("held_pulse", 32'(host_ack_o), 32'd0);
    // back-to-back reads, addr 0 then addr 1
    host_req_i  = 1'b1;
    host_addr_i = 1'b0;
    wait_ack(lat);
    check("b2b0_data", host_rdata_o, 32'd0);
    check("b2b0_sid", 32'(sid_address_o), 32'd0);
    host_addr_i = 1'b1;
    tick();
    wait_ack(lat);
    check("b2b_gap", 32'(lat + 1 >= 3 && lat + 1 <= 3 + SLACK), 32'd1);
    check("b2b1_data", host_rdata_o, EXP_TS);
    check("b2b1_sid", 32'(sid_address_o), 32'd1);
    host_req_i = 1'b0;
    tick();
    // randomized host traffic with changing slave contents
    for (int i = 0; i < 30; i++) begin
      mem[0] = $urandom;
      mem[1] = $urandom;
      repeat ($urandom_range(0, 3)) tick();
      host_read(1'($urandom_range(0, 1)));
    end
    // reset while a request is in HOST
    mem[0] = 32'd0;
    mem[1] = EXP_TS;
    do_reset();
    repeat (3) tick();
    host_req_i  = 1'b1;
    host_addr_i = 1'b1;
    tick();
    reset_i = 1'b1;
    tick();
    host_req_i = 1'b0;
    check("mid_rst_ack", 32'(host_ack_o), 32'd0);
    check("mid_rst_done", 32'(check_done_o), 32'd0);
    check("mid_rst_ok", 32'(id_ok_o), 32'd0);
    check("mid_rst_sid", 32'(sid_address_o), 32'd0);
    reset_i = 1'b0;
    tick();
    check("mid_rst_e0_done", 32'(check_done_o), 32'd0);
    check("mid_rst_e0_ack", 32'(host_ack_o), 32'd0);
    tick();
    check("mid_rst_e1_done", 32'(check_done_o), 32'd1);
    check("mid_rst_e1_ok", 32'(id_ok_o), 32'd1);
`ifdef SYSID_RECHECK_EN
    begin
      int drops = 0;
      mem[1] = 32'd5;
      for (int t = 0; t < 60 && id_ok_o; t++) begin
        tick();
        if (!check_done_o) drops++;
      end
      check("rc_done_sticky", 32'(drops), 32'd0);
      check("rc_ok", 32'(id_ok_o), 32'd0);
      check("rc_ts", ts_value_o, 32'd5);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
